// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types and constants for the A2D SPI master
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRAME1 = 3'd1,
    GAP    = 3'd2,
    FRAME2 = 3'd3,
    DONE   = 3'd4
  } a2d_state_e;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_LSB   = 11;
  localparam int RES_BITS   = 12;

  // Control word sent in both frames: channel address in bits 13:11, rest zero.
  function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [2:0] ch);
    return FRAME_BITS'(ch) << ADDR_LSB;
  endfunction

endpackage

// File: rtl/a2d_spi_frame.sv
// rtl/a2d_spi_frame.sv - one 16-bit SPI frame: SCLK divider, bit counter, shift register
module a2d_spi_frame
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] tx_word_i,
  input  logic                  miso_i,
  output logic                  done_o,
  output logic [FRAME_BITS-1:0] rx_word_o,
  output logic                  sclk_o,
  output logic                  mosi_o
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(SCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] PER_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic                  active_q;
  logic [DIV_W-1:0]      div_q;
  logic [3:0]            bit_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  miso_q;
  logic                  sclk_q;

  logic period_end;
  logic last_bit;

  assign period_end = active_q && (div_q == PER_LAST);
  assign last_bit   = (bit_q == BIT_LAST);
  assign done_o     = period_end && last_bit;
  // The final rising-edge sample is merged here so the result is ready in the done cycle.
  assign rx_word_o  = {shift_q[FRAME_BITS-2:0], miso_q};
  assign sclk_o     = sclk_q;
  assign mosi_o     = shift_q[FRAME_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      miso_q   <= 1'b0;
      sclk_q   <= 1'b1;
    end else if (start_i) begin
      active_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= tx_word_i;
      sclk_q   <= 1'b0;
    end else if (active_q) begin
      div_q <= div_q + DIV_W'(1);
      if (div_q == HALF_M1) begin
        sclk_q <= 1'b1;
        miso_q <= miso_i;
      end
      if (period_end) begin
        if (last_bit) begin
          active_q <= 1'b0;
          shift_q  <= '0;
        end else begin
          sclk_q  <= 1'b0;
          bit_q   <= bit_q + 4'd1;
          shift_q <= {shift_q[FRAME_BITS-2:0], miso_q};
        end
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - SPI master sequencing channel-address and conversion frames to the A2D
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strt_cnv,
  input  logic [2:0]          chnnl,
  input  logic                MISO,
  output logic                cnv_cmplt,
  output logic [RES_BITS-1:0] A2D_res,
  output logic                a2d_SS_n,
  output logic                SCLK,
  output logic                MOSI
);

  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  a2d_state_e            state_q;
  logic [2:0]            chnnl_q;
  logic                  launch_q;
  logic [GAP_W-1:0]      gap_q;
  logic                  ss_n_q;
  logic                  cmplt_q;
  logic [RES_BITS-1:0]   res_q;

  logic                  gap_last;
  logic                  frame_start;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] rx_word;
  logic                  unused_rx_hi;

  assign gap_last     = (state_q == GAP) && (gap_q == GAP_LAST);
  // Frame 1 starts one clock after SS_n falls; frame 2 starts right after the gap.
  assign frame_start  = launch_q | gap_last;
  assign unused_rx_hi = ^rx_word[FRAME_BITS-1:RES_BITS];

  a2d_spi_frame #(
    .SCLK_DIV(SCLK_DIV)
  ) u_frame (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (frame_start),
    .tx_word_i(ctrl_word(chnnl_q)),
    .miso_i   (MISO),
    .done_o   (frame_done),
    .rx_word_o(rx_word),
    .sclk_o   (SCLK),
    .mosi_o   (MOSI)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chnnl_q  <= '0;
      launch_q <= 1'b0;
      gap_q    <= '0;
      ss_n_q   <= 1'b1;
      cmplt_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      launch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strt_cnv) begin
            chnnl_q  <= chnnl;
            cmplt_q  <= 1'b0;
            ss_n_q   <= 1'b0;
            launch_q <= 1'b1;
            state_q  <= FRAME1;
          end
        end
        FRAME1: begin
          if (frame_done) begin
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          gap_q <= gap_q + GAP_W'(1);
          if (gap_last) state_q <= FRAME2;
        end
        FRAME2: begin
          if (frame_done) begin
            res_q   <= rx_word[RES_BITS-1:0];
            ss_n_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Completion becomes visible as IDLE is re-entered, so a start in that cycle is accepted.
          cmplt_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnv_cmplt = cmplt_q;
  assign A2D_res   = res_q;
  assign a2d_SS_n  = ss_n_q;

endmodule
